i2c_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one i2c_master between NUM_REQ independent requesters.
- Sits between requester logic and the master's addr/data_in/rw/enable/data_out/busy interface.
- Selects one request, launches a single byte transaction, tracks busy to completion with timeouts, and returns read data, done and error to the granted requester.

---
 rtl/i2c_req_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
//------------------------------------------------------------------------------
// Module      : i2c_req_arbiter
// Description : Round-robin arbiter/sequencer sharing one i2c_master between
//               NUM_REQ requesters, with start and busy timeouts.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_req_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int START_WAIT     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]   req_rw,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic [7:0]           rdata,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_data_in,
    output logic                 m_rw,
    output logic                 m_enable,
    input  logic [7:0]           m_data_out,
    input  logic                 m_busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_nstate;
    logic [IW-1:0]      r_idx;
    logic [IW-1:0]      r_last;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_inc;
    logic               r_tout;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_err;
    logic               r_men;
    logic [7:0]         r_rdata;
    logic [6:0]         r_maddr;
    logic [7:0]         r_mdata;
    logic               r_mrw;

    logic               w_go;
    logic [IW-1:0]      w_pick;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic [NUM_REQ-1:0] w_idx_oh;
    logic [NUM_REQ-1:0] w_gnt_d;
    logic [NUM_REQ-1:0] w_done_d;
    logic [NUM_REQ-1:0] w_err_d;
    logic               w_men_d;

    assign w_go      = (|req) && !m_busy;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_pick_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
    assign w_idx_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;

    // Scan upward from the requester after the last one served, wrapping.
    always_comb begin
        int p;
        logic found;
        p      = 0;
        found  = 1'b0;
        w_pick = r_last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            p = int'(r_last) + k;
            if (p >= NUM_REQ) p = p - NUM_REQ;
            if (!found && req[p]) begin
                found  = 1'b1;
                w_pick = IW'(p);
            end
        end
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_IDLE:   if (w_go) w_nstate = S_LAUNCH;
            S_LAUNCH: w_nstate = S_WAIT;
            S_WAIT: begin
                if (m_busy)                               w_nstate = S_RUN;
                else if (r_cnt == CW'(START_WAIT - 1))    w_nstate = S_FINISH;
            end
            S_RUN: begin
                if (!m_busy)                              w_nstate = S_FINISH;
                else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) w_nstate = S_FINISH;
            end
            S_FINISH: w_nstate = S_IDLE;
            default:  w_nstate = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_d  = r_gnt;
        w_done_d = '0;
        w_err_d  = '0;
        w_men_d  = 1'b0;
        case (r_state)
            S_IDLE:   if (w_go) w_gnt_d = w_pick_oh;
            S_LAUNCH: w_men_d = 1'b1;
            S_FINISH: begin
                w_gnt_d  = '0;
                w_done_d = w_idx_oh;
                w_err_d  = r_tout ? w_idx_oh : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_last  <= IW'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_tout  <= 1'b0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_men   <= 1'b0;
            r_rdata <= '0;
            r_maddr <= '0;
            r_mdata <= '0;
            r_mrw   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_gnt   <= w_gnt_d;
            r_done  <= w_done_d;
            r_err   <= w_err_d;
            r_men   <= w_men_d;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_idx   <= w_pick;
                        r_maddr <= req_addr[7*int'(w_pick) +: 7];
                        r_mdata <= req_wdata[8*int'(w_pick) +: 8];
                        r_mrw   <= req_rw[w_pick];
                        r_tout  <= 1'b0;
                    end
                end
                S_LAUNCH: r_cnt <= '0;
                S_WAIT: begin
                    if (m_busy) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (r_cnt == CW'(START_WAIT - 1)) r_tout <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!m_busy) begin
                        if (r_mrw) r_rdata <= m_data_out;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) r_tout <= 1'b1;
                    end
                end
                S_FINISH: r_last <= r_idx;
                default: ;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign m_addr    = r_maddr;
    assign m_data_in = r_mdata;
    assign m_rw      = r_mrw;
    assign m_enable  = r_men;

endmodule

`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_i2c_req_arbiter
// Description : Directed self-checking bench for i2c_req_arbiter.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_req_arbiter;

    localparam int NR = 3;
    localparam int SW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          areset;
    logic [NR-1:0] req;
    logic [20:0]   req_addr;
    logic [23:0]   req_wdata;
    logic [NR-1:0] req_rw;
    logic [NR-1:0] gnt, done, err;
    logic [7:0]    rdata;
    logic [6:0]    m_addr;
    logic [7:0]    m_data_in;
    logic          m_rw, m_enable;
    logic [7:0]    m_data_out;
    logic          m_busy;

    typedef struct {
        int         idx;
        logic       terr;
        logic [7:0] rd;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    i2c_req_arbiter #(.NUM_REQ(NR), .START_WAIT(SW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .areset(areset), .req(req), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rw(req_rw), .gnt(gnt), .done(done),
        .err(err), .rdata(rdata), .m_addr(m_addr), .m_data_in(m_data_in),
        .m_rw(m_rw), .m_enable(m_enable), .m_data_out(m_data_out), .m_busy(m_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input int idx);
        int n;
        logic [2:0] oh;
        n  = 0;
        oh = 3'b001 << idx;
        while (gnt == '0 && n < 50) begin
            tick();
            n++;
        end
        chk("gnt", gnt, oh);
    endtask

    task automatic wait_done(input int exp_lat, input logic [2:0] dmask);
        int n;
        exp_t e;
        logic [2:0] oh;
        n = 0;
        while (done == '0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_lat >= 0) chk("done_latency", n, exp_lat);
        if (sb.size() == 0) begin
            chk("done_unexpected", done, 3'b000);
        end else begin
            e  = sb.pop_front();
            oh = 3'b001 << e.idx;
            chk("done", done, oh);
            chk("err", err, e.terr ? oh : 3'b000);
            chk("rdata", rdata, e.rd);
            chk("gnt_cleared", gnt, 3'b000);
        end
        req = req & ~dmask;
        tick();
        chk("done_one_cycle", done, 3'b000);
    endtask

    // Normal transaction: master raises busy right after enable, runs 4 cycles.
    task automatic txn_normal(input int idx, input logic [6:0] a, input logic rw,
                              input logic [7:0] wd, input logic [7:0] sbyte,
                              input logic [7:0] exp_rd, input logic [2:0] dmask);
        int en_cnt;
        sb.push_back('{idx, 1'b0, exp_rd});
        wait_grant(idx);
        chk("m_addr", m_addr, a);
        chk("m_rw", m_rw, rw);
        if (!rw) chk("m_data_in", m_data_in, wd);
        chk("m_enable_pre", m_enable, 1'b0);
        tick();
        chk("m_enable_pulse", m_enable, 1'b1);
        req_addr[7*idx +: 7]  = ~a;
        req_wdata[8*idx +: 8] = ~wd;
        req_rw[idx]           = ~rw;
        m_busy     = 1'b1;
        m_data_out = sbyte;
        en_cnt     = 0;
        repeat (4) begin
            tick();
            if (m_enable) en_cnt++;
        end
        chk("m_enable_once", en_cnt, 0);
        chk("m_addr_stable", m_addr, a);
        chk("m_rw_stable", m_rw, rw);
        if (!rw) chk("m_data_in_stable", m_data_in, wd);
        req_addr[7*idx +: 7]  = a;
        req_wdata[8*idx +: 8] = wd;
        req_rw[idx]           = rw;
        m_busy = 1'b0;
        wait_done(2, dmask);
    endtask

    initial begin
        areset     = 1'b1;
        req        = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_rw     = '0;
        m_data_out = '0;
        m_busy     = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_done", done, 3'b000);
        chk("rst_err", err, 3'b000);
        chk("rst_outs", {rdata, m_addr, m_data_in, m_rw, m_enable}, 25'd0);
        areset = 1'b0;
        tick();

        // All requesters held, all reads: grants 0,1,2,0.
        req_addr = {7'b1011001, 7'b1011000, 7'b1010111};
        req_rw   = 3'b111;
        req      = 3'b111;
        txn_normal(0, 7'b1010111, 1'b1, 8'h00, 8'hCD, 8'hCD, 3'b000);
        txn_normal(1, 7'b1011000, 1'b1, 8'h00, 8'hF0, 8'hF0, 3'b000);
        txn_normal(2, 7'b1011001, 1'b1, 8'h00, 8'h3C, 8'h3C, 3'b000);
        txn_normal(0, 7'b1010111, 1'b1, 8'h00, 8'h5A, 8'h5A, 3'b111);
        tick();
        chk("idle_no_gnt", gnt, 3'b000);

        // Write by requester 1; rdata retained.
        req_addr[13:7]  = 7'h20;
        req_wdata[15:8] = 8'hA5;
        req_rw[1]       = 1'b0;
        req[1]          = 1'b1;
        txn_normal(1, 7'h20, 1'b0, 8'hA5, 8'hEE, 8'h5A, 3'b010);

        // Busy never rises: start timeout on requester 1 (read, rdata kept).
        req_rw[1]  = 1'b1;
        req[1]     = 1'b1;
        m_data_out = 8'h99;
        sb.push_back('{1, 1'b1, 8'h5A});
        wait_grant(1);
        wait_done(SW + 2, 3'b010);

        // Busy stuck high on requester 2; requester 0 queued meanwhile.
        req_addr[20:14] = 7'h33;
        req_rw[2]       = 1'b1;
        req[2]          = 1'b1;
        sb.push_back('{2, 1'b1, 8'h5A});
        wait_grant(2);
        tick();
        m_busy = 1'b1;
        req_addr[6:0] = 7'h11;
        req_rw[0]     = 1'b1;
        req[0]        = 1'b1;
        wait_done(TO + 2, 3'b100);
        m_busy = 1'b0;
        txn_normal(0, 7'h11, 1'b1, 8'h00, 8'h81, 8'h81, 3'b001);

        // External busy blocks arbitration.
        m_busy = 1'b1;
        req[2] = 1'b1;
        repeat (6) tick();
        chk("busy_blocks_gnt", gnt, 3'b000);
        m_busy = 1'b0;
        wait_grant(2);
        tick();
        m_busy = 1'b1;
        repeat (3) tick();

        // Reset while in RUN aborts with no done.
        areset = 1'b1;
        tick();
        chk("rst_run_gnt", gnt, 3'b000);
        chk("rst_run_done", done, 3'b000);
        chk("rst_run_err", err, 3'b000);
        chk("rst_run_outs", {rdata, m_addr, m_data_in, m_rw, m_enable}, 25'd0);
        tick();
        m_busy = 1'b0;
        req[0] = 1'b1;
        areset = 1'b0;
        tick();
        chk("no_done_after_rst", done, 3'b000);
        txn_normal(0, 7'h11, 1'b1, 8'h00, 8'h77, 8'h77, 3'b001);
        txn_normal(2, 7'h33, 1'b1, 8'h00, 8'h44, 8'h44, 3'b100);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
